// File: rtl/cin_pack_converter.sv
// Packs R narrow input beats (R = 1, 2 or 4, chosen at runtime) into one full-width
// feature beat. A beat with S_Last set flushes a partial group with zero-filled upper slots.
module cin_pack_converter #(
    parameter int WIDTH_DATA     = 8,
    parameter int PICTURE_NUM    = 1,
    parameter int CHANNEL_IN_NUM = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [1:0]                                    Mode,
    input  logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM-1:0] S_Feature,
    input  logic                                          S_Valid,
    input  logic                                          S_Last,
    output logic                                          S_Ready,
    output logic [WIDTH_DATA*PICTURE_NUM*CHANNEL_IN_NUM-1:0] M_Feature,
    output logic                                          M_Valid,
    output logic                                          M_Last,
    input  logic                                          M_Ready,
    output logic                                          Busy
);

    localparam int LANE_W = WIDTH_DATA * PICTURE_NUM;
    localparam int BUS_W  = LANE_W * CHANNEL_IN_NUM;
    localparam int Q_W    = BUS_W / 4;

    // Ratios are held as R-1 (0, 1 or 3) so they compare directly against the slot counter.
    logic [1:0]       cnt_reg;
    logic [1:0]       ratio_reg;
    logic [BUS_W-1:0] acc_reg;
    logic [BUS_W-1:0] m_feature_reg;
    logic             m_valid_reg;
    logic             m_last_reg;

    logic [1:0]       mode_rm1;
    logic [1:0]       cur_rm1;
    logic             complete;
    logic             accept;
    logic [BUS_W-1:0] placed;
    logic [BUS_W-1:0] merged;

    always_comb begin
        case (Mode)
            2'b01:   mode_rm1 = 2'd1;
            2'b10:   mode_rm1 = 2'd3;
            default: mode_rm1 = 2'd0;
        endcase
    end

    // Mode only matters at the start of a group; mid-group the latched ratio rules.
    assign cur_rm1  = (cnt_reg == 2'd0) ? mode_rm1 : ratio_reg;
    assign complete = (cnt_reg == cur_rm1) | S_Last;
    assign S_Ready  = complete ? (!m_valid_reg | M_Ready) : 1'b1;
    assign accept   = S_Valid & S_Ready;

    // Each quarter of the output picks the input quarter that lands there for the current slot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_quarter
            logic [Q_W-1:0] q;
            assign q = (cur_rm1 == 2'd0) ? S_Feature[gi*Q_W +: Q_W] :
                       (cur_rm1 == 2'd1 && cnt_reg[0] == 1'(gi / 2)) ? S_Feature[(gi % 2)*Q_W +: Q_W] :
                       (cur_rm1 == 2'd3 && cnt_reg == 2'(gi)) ? S_Feature[Q_W-1:0] :
                       '0;
            assign placed[gi*Q_W +: Q_W] = q;
        end
    endgenerate

    assign merged = acc_reg | placed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= 2'd0;
            ratio_reg     <= 2'd0;
            acc_reg       <= '0;
            m_feature_reg <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
        end else begin
            if (accept && cnt_reg == 2'd0) begin
                ratio_reg <= mode_rm1;
            end
            if (accept && complete) begin
                m_feature_reg <= merged;
                m_last_reg    <= S_Last;
                m_valid_reg   <= 1'b1;
                acc_reg       <= '0;
                cnt_reg       <= 2'd0;
            end else begin
                if (M_Ready) begin
                    m_valid_reg <= 1'b0;
                end
                if (accept) begin
                    acc_reg <= merged;
                    cnt_reg <= cnt_reg + 2'd1;
                end
            end
        end
    end

    assign M_Feature = m_feature_reg;
    assign M_Valid   = m_valid_reg;
    assign M_Last    = m_last_reg;
    assign Busy      = (cnt_reg != 2'd0);

endmodule

// File: tb/tb_cin_pack_converter.sv
// Directed bench for cin_pack_converter: expected beats are queued at stimulus time and a
// forked monitor pops and compares them on every output handshake.
module tb_cin_pack_converter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   Mode = 2'b00;
    logic [127:0] S_Feature = '0;
    logic         S_Valid = 1'b0;
    logic         S_Last = 1'b0;
    logic         S_Ready;
    logic [127:0] M_Feature;
    logic         M_Valid;
    logic         M_Last;
    logic         M_Ready = 1'b1;
    logic         Busy;

    int tests = 0;
    int fails = 0;
    logic [128:0] exp_q[$];

    cin_pack_converter #(.WIDTH_DATA(8), .PICTURE_NUM(1), .CHANNEL_IN_NUM(16)) dut (
        .clk(clk), .rst(rst), .Mode(Mode),
        .S_Feature(S_Feature), .S_Valid(S_Valid), .S_Last(S_Last), .S_Ready(S_Ready),
        .M_Feature(M_Feature), .M_Valid(M_Valid), .M_Last(M_Last), .M_Ready(M_Ready),
        .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (!rst && M_Valid && M_Ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got %h with nothing expected", M_Feature);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", M_Feature, e[127:0]);
                    check("out_last", {127'd0, M_Last}, {127'd0, e[128]});
                    $display("[TB] out %h last %b", M_Feature, M_Last);
                end
            end
        end
    endtask

    // Holds the beat until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [127:0] d, input logic last);
        S_Feature = d;
        S_Last    = last;
        S_Valid   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (S_Ready) begin
                @(posedge clk);
                #1;
                S_Valid = 1'b0;
                S_Last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: got no S_Ready expected accept within 50 cycles");
        S_Valid = 1'b0;
        S_Last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !M_Valid) return;
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_m_valid", {127'd0, M_Valid}, 128'd0);
        check("rst_m_feature", M_Feature, 128'd0);
        check("rst_m_last", {127'd0, M_Last}, 128'd0);
        check("rst_busy", {127'd0, Busy}, 128'd0);
        check("rst_s_ready", {127'd0, S_Ready}, 128'd1);

        // R=1 pass-through, one cycle latency, last on beat 5
        Mode = 2'b00;
        for (int i = 0; i < 5; i++) begin
            b = 8'h30 + 8'(i);
            exp_q.push_back({(i == 4), {16{b}}});
            send({16{b}}, (i == 4));
            check("r1_latency", {127'd0, M_Valid}, 128'd1);
        end
        drain();

        // Mode 11 behaves as pass-through
        Mode = 2'b11;
        exp_q.push_back({1'b1, 128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C});
        send(128'hCAFEF00D_12345678_9ABCDEF0_0F1E2D3C, 1'b1);
        drain();

        // R=2: high halves of inputs must be ignored
        Mode = 2'b01;
        exp_q.push_back({1'b0, 128'h18171615141312110807060504030201});
        send({64'hFFFFFFFFFFFFFFFF, 64'h0807060504030201}, 1'b0);
        check("r2_no_early_out", {127'd0, M_Valid}, 128'd0);
        send({64'hEEEEEEEEEEEEEEEE, 64'h1817161514131211}, 1'b0);
        check("r2_latency", {127'd0, M_Valid}, 128'd1);
        drain();

        // R=4 flushed after 3 beats
        Mode = 2'b10;
        exp_q.push_back({1'b1, 128'h00000000_34333231_24232221_04030201});
        send({96'hAAAAAAAAAAAAAAAAAAAAAAAA, 32'h04030201}, 1'b0);
        send({96'hAAAAAAAAAAAAAAAAAAAAAAAA, 32'h24232221}, 1'b0);
        send({96'hAAAAAAAAAAAAAAAAAAAAAAAA, 32'h34333231}, 1'b1);
        check("flush_busy", {127'd0, Busy}, 128'd0);
        drain();

        // R=4 with downstream stalled: two groups, S_Ready drops only on beat 8
        M_Ready = 1'b0;
        exp_q.push_back({1'b0, 128'h44444444333333332222222211111111});
        exp_q.push_back({1'b0, 128'h88888888777777776666666655555555});
        for (int i = 0; i < 7; i++) begin
            w = 32'(32'h11111111 * (i + 1));
            send({96'hBBBBBBBBBBBBBBBBBBBBBBBB, w}, 1'b0);
        end
        S_Feature = {96'hBBBBBBBBBBBBBBBBBBBBBBBB, 32'h88888888};
        S_Valid   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_s_ready", {127'd0, S_Ready}, 128'd0);
            check("stall_m_valid", {127'd0, M_Valid}, 128'd1);
            check("stall_hold", M_Feature, 128'h44444444333333332222222211111111);
        end
        @(posedge clk);
        #1;
        M_Ready = 1'b1;
        @(negedge clk);
        check("unstall_s_ready", {127'd0, S_Ready}, 128'd1);
        @(posedge clk);
        #1;
        S_Valid = 1'b0;
        check("reload_m_valid", {127'd0, M_Valid}, 128'd1);
        drain();

        // Mode change mid-group takes effect on the next group
        Mode = 2'b01;
        exp_q.push_back({1'b0, 128'h1112131415161718_0102030405060708});
        exp_q.push_back({1'b1, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1});
        send({64'hCCCCCCCCCCCCCCCC, 64'h0102030405060708}, 1'b0);
        check("switch_busy", {127'd0, Busy}, 128'd1);
        Mode = 2'b10;
        send({64'hCCCCCCCCCCCCCCCC, 64'h1112131415161718}, 1'b0);
        send({96'hCCCCCCCCCCCCCCCCCCCCCCCC, 32'hA1A1A1A1}, 1'b0);
        send({96'hCCCCCCCCCCCCCCCCCCCCCCCC, 32'hA2A2A2A2}, 1'b0);
        send({96'hCCCCCCCCCCCCCCCCCCCCCCCC, 32'hA3A3A3A3}, 1'b0);
        send({96'hCCCCCCCCCCCCCCCCCCCCCCCC, 32'hA4A4A4A4}, 1'b1);
        drain();

        // Reset mid-group discards the partial group
        send({96'hDDDDDDDDDDDDDDDDDDDDDDDD, 32'hEEEEEEEE}, 1'b0);
        send({96'hDDDDDDDDDDDDDDDDDDDDDDDD, 32'hEEEEEEEE}, 1'b0);
        check("pre_rst_busy", {127'd0, Busy}, 128'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_m_valid", {127'd0, M_Valid}, 128'd0);
        check("mid_rst_busy", {127'd0, Busy}, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back({1'b0, 128'hD4D4D4D4_D3D3D3D3_D2D2D2D2_D1D1D1D1});
        send({96'h0, 32'hD1D1D1D1}, 1'b0);
        send({96'h0, 32'hD2D2D2D2}, 1'b0);
        send({96'h0, 32'hD3D3D3D3}, 1'b0);
        send({96'h0, 32'hD4D4D4D4}, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d beats unseen expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
